// File: rtl/fsm_seq_ctrl_if.sv
// Word request / result response bundle for the "101" sequencing controller.
// The slave modport is the controller side; master is the producer/consumer side.
interface fsm_seq_ctrl_if #(
    parameter int NBITS = 8,
    parameter int CNT_W = 4
);
    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in_msg;
    logic             in_restart;
    logic             out_val;
    logic             out_rdy;
    logic [CNT_W-1:0] out_count;
    logic [3:0]       out_state;
    logic             out_last;
    logic             busy;

    modport master (
        output in_val, in_msg, in_restart, out_rdy,
        input  in_rdy, out_val, out_count, out_state, out_last, busy
    );

    modport slave (
        input  in_val, in_msg, in_restart, out_rdy,
        output in_rdy, out_val, out_count, out_state, out_last, busy
    );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// Feeds NBITS-wide words MSB-first into a one-hot "101" overlap detector, counting D entries.
// Result valid NBITS edges after accept; result held in DONE until out_rdy, in_rdy low meanwhile.
module fsm_seq_ctrl #(
    parameter int NBITS = 8,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    fsm_seq_ctrl_if.slave bus
);
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(NBITS - 1);

    localparam logic [3:0] ST_A = 4'b0001;
    localparam logic [3:0] ST_B = 4'b0010;
    localparam logic [3:0] ST_C = 4'b0100;
    localparam logic [3:0] ST_D = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_t;

    ctrl_t            ctrl;
    logic [NBITS-1:0] msg;
    logic [IDX_W-1:0] idx;
    logic [3:0]       fsm;
    logic [CNT_W-1:0] count;
    logic             last;
    logic [3:0]       fsm_nxt;

    // Illegal (non-one-hot) encodings fall into the A row so the detector self-recovers.
    function automatic logic [3:0] fsm_next(input logic [3:0] s, input logic b);
        logic [3:0] n;
        case (s)
            ST_B:    n = b ? ST_B : ST_C;
            ST_C:    n = b ? ST_D : ST_A;
            ST_D:    n = b ? ST_B : ST_C;
            default: n = b ? ST_B : ST_A;
        endcase
        return n;
    endfunction

    assign fsm_nxt = fsm_next(fsm, msg[idx]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl  <= IDLE;
            msg   <= '0;
            idx   <= '0;
            fsm   <= ST_A;
            count <= '0;
            last  <= 1'b0;
        end else begin
            case (ctrl)
                IDLE: begin
                    if (bus.in_val) begin
                        msg   <= bus.in_msg;
                        count <= '0;
                        idx   <= IDX_INIT;
                        ctrl  <= SHIFT;
                        if (bus.in_restart) begin
                            fsm  <= ST_A;
                            last <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    fsm  <= fsm_nxt;
                    last <= (fsm_nxt == ST_D);
                    if (fsm_nxt == ST_D) begin
                        count <= count + CNT_W'(1);
                    end
                    if (idx == '0) begin
                        ctrl <= DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_rdy) begin
                        ctrl <= IDLE;
                    end
                end
                default: ctrl <= IDLE;
            endcase
        end
    end

    assign bus.in_rdy    = (ctrl == IDLE);
    assign bus.out_val   = (ctrl == DONE);
    assign bus.busy      = (ctrl != IDLE);
    assign bus.out_count = count;
    assign bus.out_state = fsm;
    assign bus.out_last  = last;
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: directed words plus random words with random backpressure,
// compared against a table-driven reference of the "101" detector.
module tb_fsm_seq_ctrl;
    localparam int NBITS = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference detector: states 0..3 = A..D, indexed [state][bit].
    int ref_st = 0;
    int trans [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};

    fsm_seq_ctrl_if #(.NBITS(NBITS), .CNT_W(CNT_W)) bus ();

    fsm_seq_ctrl #(.NBITS(NBITS), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic ref_word(input logic [NBITS-1:0] m, input logic rs,
                            output int cnt, output int st);
        if (rs) ref_st = 0;
        cnt = 0;
        for (int i = NBITS - 1; i >= 0; i--) begin
            ref_st = trans[ref_st][m[i]];
            if (ref_st == 3) cnt++;
        end
        st = ref_st;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_rdy"},    bus.in_rdy, 1);
        chk({tag, "_out_val"},   bus.out_val, 0);
        chk({tag, "_busy"},      bus.busy, 0);
        chk({tag, "_out_count"}, bus.out_count, 0);
        chk({tag, "_out_state"}, bus.out_state, 4'b0001);
        chk({tag, "_out_last"},  bus.out_last, 0);
    endtask

    task automatic send_word(input logic [NBITS-1:0] m, input logic rs, input int bp,
                             output int cnt, output int st);
        int lat;
        ref_word(m, rs, cnt, st);
        @(negedge clk);
        chk("in_rdy_idle", bus.in_rdy, 1);
        bus.in_val     = 1'b1;
        bus.in_msg     = m;
        bus.in_restart = rs;
        bus.out_rdy    = 1'b0;
        @(posedge clk); #1;
        chk("busy_after_accept", bus.busy, 1);
        chk("in_rdy_in_shift", bus.in_rdy, 0);
        lat = 0;
        while (!bus.out_val && lat < 4 * NBITS) begin
            @(negedge clk);
            bus.in_val     = 1'($urandom_range(0, 1));
            bus.in_msg     = NBITS'($urandom);
            bus.in_restart = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, NBITS);
        chk("out_count", bus.out_count, cnt);
        chk("out_state", bus.out_state, 4'b0001 << st);
        chk("out_last",  bus.out_last, (st == 3) ? 1 : 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            bus.in_val  = 1'b1;
            bus.in_msg  = NBITS'($urandom);
            bus.out_rdy = 1'b0;
            @(posedge clk); #1;
            chk("bp_out_val",   bus.out_val, 1);
            chk("bp_in_rdy",    bus.in_rdy, 0);
            chk("bp_out_count", bus.out_count, cnt);
            chk("bp_out_state", bus.out_state, 4'b0001 << st);
        end
        @(negedge clk);
        bus.in_val  = 1'b0;
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        chk("drain_out_val", bus.out_val, 0);
        chk("drain_in_rdy",  bus.in_rdy, 1);
        chk("drain_busy",    bus.busy, 0);
    endtask

    initial begin
        int cnt, st;
        logic [NBITS-1:0] m;
        bus.in_val     = 1'b0;
        bus.in_msg     = '0;
        bus.in_restart = 1'b0;
        bus.out_rdy    = 1'b0;

        #3 reset_n = 1'b0;
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        ref_st = 0;

        send_word(8'b10101010, 1'b1, 0, cnt, st);
        chk("tp1_count", cnt, 3);
        chk("tp1_state", st, 2);
        send_word(8'b00000101, 1'b1, 0, cnt, st);
        chk("tp2_count", cnt, 1);
        chk("tp2_state", st, 3);
        send_word(8'h40, 1'b0, 0, cnt, st);
        chk("tp3_count", cnt, 1);
        chk("tp3_state", st, 0);
        send_word(8'h40, 1'b1, 5, cnt, st);
        chk("tp4_count", cnt, 0);
        chk("tp4_state", st, 0);

        // Reset mid-SHIFT while bit 3 of 0xFF is being scanned.
        @(negedge clk);
        bus.in_val     = 1'b1;
        bus.in_msg     = 8'hFF;
        bus.in_restart = 1'b1;
        bus.out_rdy    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_val = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("mid_shift_reset");
        ref_st = 0;
        @(negedge clk);
        reset_n = 1'b1;
        send_word(8'b01010101, 1'b0, 0, cnt, st);
        chk("tp6_count", cnt, 3);
        chk("tp6_state", st, 3);

        for (int k = 0; k < 40; k++) begin
            m = NBITS'($urandom);
            send_word(m, 1'($urandom_range(0, 1)), $urandom_range(0, 3), cnt, st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
